bufer_reader: RTL and testbench

// - Drains the ping-pong capture buffer filled by the FSMC-side data writer, toward the MCU over FSMC.
// - On each writer BUFER_CHANGE toggle, takes the just-filled bank, prefetches word 0 and raises DATA_READY (MCU IRQ).
// - Serves one word per FSMC read strobe (NE & NOE low) and drops DATA_READY after BUF_LEN words.
// - Sits between the buffer RAM read port and the FSMC data-bus tristate.

---
 rtl/bufer_reader_pkg.sv | 15 +
 rtl/bufer_reader_if.sv | 30 +++
 rtl/bufer_reader_sync_edge.sv | 32 +++
 rtl/bufer_reader.sv | 157 +++++++++++++++
 tb/tb_bufer_reader.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/bufer_reader_pkg.sv
// rtl/bufer_reader_pkg.sv - shared widths, bank length and reader state encoding
package bufer_reader_pkg;

    localparam int FSMC_WIDTH     = 16;
    localparam int DATA_READ_RAZR = 16;
    localparam int LENTH_BUFER    = 1024;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_READY = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/bufer_reader_if.sv
// rtl/bufer_reader_if.sv - writer/FSMC/RAM-side signal bundle of the buffer reader
// master: reader side (drives RAM read port and FSMC data), slave: environment side.
interface bufer_reader_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              BUFER_CHANGE;
    logic              BUFER_EN;
    logic              FSMC_NE;
    logic              FSMC_NOE;
    logic [DATA_W-1:0] MEM_DATA;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic              MEM_SEL;
    logic              MEM_RD;
    logic [DATA_W-1:0] DATA_OUT;
    logic              DATA_OE;
    logic              DATA_READY;
    logic              OVERRUN;
    logic [ADDR_W-1:0] WORD_CNT;

    modport master (
        input  BUFER_CHANGE, BUFER_EN, FSMC_NE, FSMC_NOE, MEM_DATA,
        output MEM_ADDR, MEM_SEL, MEM_RD, DATA_OUT, DATA_OE, DATA_READY, OVERRUN, WORD_CNT
    );

    modport slave (
        output BUFER_CHANGE, BUFER_EN, FSMC_NE, FSMC_NOE, MEM_DATA,
        input  MEM_ADDR, MEM_SEL, MEM_RD, DATA_OUT, DATA_OE, DATA_READY, OVERRUN, WORD_CNT
    );
endinterface

// File: rtl/bufer_reader_sync_edge.sv
// rtl/bufer_reader_sync_edge.sv - 2-FF synchronizer with rise/fall pulses
// Ports: clk_i, rst_ni (async active-low), async_i (line to sync),
//        sync_o (synchronized level), rise_o / fall_o (one-cycle edge pulses of sync_o).
module bufer_reader_sync_edge #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);
    logic meta_q, sync_q, prev_q;

    // Reset to the idle level of the strobe so release never fakes an edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
            prev_q <= RST_VAL;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_o = sync_q;
    assign rise_o = sync_q & ~prev_q;
    assign fall_o = ~sync_q & prev_q;
endmodule

// File: rtl/bufer_reader.sv
// rtl/bufer_reader.sv - ping-pong capture buffer drain toward the MCU over FSMC
// Ports: CLK, RESET (async active-low), bus (bufer_reader_if.master): writer toggle and
//        enable, FSMC NE/NOE strobes, RAM read port, FSMC data/OE, DATA_READY, OVERRUN, WORD_CNT.
module bufer_reader
    import bufer_reader_pkg::*;
#(
    parameter int DATA_W  = FSMC_WIDTH,
    parameter int ADDR_W  = DATA_READ_RAZR,
    parameter int BUF_LEN = LENTH_BUFER,
    parameter int RD_LAT  = 1
) (
    input  logic             CLK,
    input  logic             RESET,
    bufer_reader_if.master   bus
);
    localparam logic [ADDR_W-1:0] LEN_W = ADDR_W'(BUF_LEN);
    localparam logic [1:0]        LAT_W = 2'(RD_LAT);

    state_e            state_q, state_d;
    logic              chg_q, arm_q;
    logic              sel_q, sel_d;
    logic [ADDR_W-1:0] addr_q, addr_d, cnt_q, cnt_d, cnt_inc;
    logic              rd_q, rd_d;
    logic [1:0]        wait_q, wait_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              oe_q, oe_d, ready_q, ready_d, ovr_q, ovr_d;

    logic ne_s, ne_rise, ne_fall, noe_s, noe_rise, noe_fall;
    logic rd_act, rd_start, rd_end, tgl, collide, word_end, last;

    bufer_reader_sync_edge u_sync_ne (
        .clk_i(CLK), .rst_ni(RESET), .async_i(bus.FSMC_NE),
        .sync_o(ne_s), .rise_o(ne_rise), .fall_o(ne_fall)
    );
    bufer_reader_sync_edge u_sync_noe (
        .clk_i(CLK), .rst_ni(RESET), .async_i(bus.FSMC_NOE),
        .sync_o(noe_s), .rise_o(noe_rise), .fall_o(noe_fall)
    );

    // rd_act edges rebuilt from the per-line edges: a line was low last cycle
    // if it just rose, or it is low now and did not just fall.
    assign rd_act   = ~ne_s & ~noe_s;
    assign rd_start = rd_act & (ne_fall | noe_fall);
    assign rd_end   = (ne_rise | noe_rise)
                    & (ne_rise  | (~ne_s  & ~ne_fall))
                    & (noe_rise | (~noe_s & ~noe_fall));

    // arm_q masks the first cycle after reset so chg_q can pick up the live level.
    assign tgl      = arm_q & (bus.BUFER_CHANGE != chg_q);
    assign collide  = bus.BUFER_EN & (sel_q == bus.BUFER_CHANGE) & (state_q != ST_IDLE);
    assign word_end = (state_q == ST_READY) & rd_end & oe_q;
    assign cnt_inc  = cnt_q + 1'b1;
    assign last     = (cnt_inc == LEN_W);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (tgl) begin
            state_d = ST_FETCH;
        end else begin
            case (state_q)
                ST_FETCH: if (wait_q == 2'd0) state_d = ST_READY;
                ST_READY: if (word_end) state_d = last ? ST_DONE : ST_FETCH;
                ST_DONE:  state_d = ST_IDLE;
                default:  state_d = state_q;
            endcase
        end
    end

    always_comb begin
        sel_d   = sel_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        wait_d  = wait_q;
        dout_d  = dout_q;
        ready_d = ready_q;
        ovr_d   = ovr_q | collide;
        rd_d    = 1'b0;
        oe_d    = 1'b0;
        if (tgl) begin
            sel_d   = ~bus.BUFER_CHANGE;
            addr_d  = '0;
            cnt_d   = '0;
            ready_d = 1'b0;
            rd_d    = 1'b1;
            wait_d  = LAT_W;
            if (state_q != ST_IDLE) ovr_d = 1'b1;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (wait_q == 2'd0) begin
                        dout_d  = bus.MEM_DATA;
                        ready_d = 1'b1;
                    end else begin
                        wait_d = wait_q - 1'b1;
                    end
                end
                ST_READY: begin
                    // Only strobes that begin in READY drive the bus; one held
                    // across a bank change is ignored until it is released.
                    oe_d = rd_act & (rd_start | oe_q);
                    if (word_end) begin
                        cnt_d = cnt_inc;
                        if (!last) begin
                            addr_d = addr_q + 1'b1;
                            rd_d   = 1'b1;
                            wait_d = LAT_W;
                        end
                    end
                end
                ST_DONE:  ready_d = 1'b0;
                default:  ready_d = ready_q;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            chg_q   <= 1'b0;
            arm_q   <= 1'b0;
            sel_q   <= 1'b0;
            addr_q  <= '0;
            cnt_q   <= '0;
            rd_q    <= 1'b0;
            wait_q  <= 2'd0;
            dout_q  <= '0;
            oe_q    <= 1'b0;
            ready_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            chg_q   <= bus.BUFER_CHANGE;
            arm_q   <= 1'b1;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            wait_q  <= wait_d;
            dout_q  <= dout_d;
            oe_q    <= oe_d;
            ready_q <= ready_d;
            ovr_q   <= ovr_d;
        end
    end

    assign bus.MEM_ADDR   = addr_q;
    assign bus.MEM_SEL    = sel_q;
    assign bus.MEM_RD     = rd_q;
    assign bus.DATA_OUT   = dout_q;
    assign bus.DATA_OE    = oe_q;
    assign bus.DATA_READY = ready_q;
    assign bus.OVERRUN    = ovr_q;
    assign bus.WORD_CNT   = cnt_q;
endmodule

// File: tb/tb_bufer_reader.sv
// tb/tb_bufer_reader.sv - self-checking bench for bufer_reader (BUF_LEN=4, RD_LAT=1)
module tb_bufer_reader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bufer_reader_if #(.DATA_W(16), .ADDR_W(16)) bus ();

    bufer_reader #(.DATA_W(16), .ADDR_W(16), .BUF_LEN(4), .RD_LAT(1)) dut (
        .CLK(clk), .RESET(rst_n), .bus(bus.master)
    );

    logic [15:0] mem [2][4];
    always @(posedge clk) bus.MEM_DATA <= mem[bus.MEM_SEL][bus.MEM_ADDR[1:0]];

    int n_chk = 0;
    int n_pass = 0;
    logic [15:0] sb_q[$];

    typedef struct {
        bit oe;
        int cnt;
        int addr;
        bit rdy;
    } vec_t;
    vec_t tbl[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    function automatic logic [63:0] outs();
        return {11'd0, bus.MEM_ADDR, bus.MEM_SEL, bus.MEM_RD, bus.DATA_OUT,
                bus.DATA_OE, bus.DATA_READY, bus.OVERRUN, bus.WORD_CNT};
    endfunction

    function automatic logic [15:0] bank_word(input int b, input int i);
        logic [15:0] base;
        base = (b != 0) ? 16'hB000 : 16'hA000;
        return base + 16'(i);
    endfunction

    task automatic push_bank(input int b);
        for (int i = 0; i < 4; i++) sb_q.push_back(bank_word(b, i));
    endtask

    task automatic toggle();
        @(negedge clk);
        bus.BUFER_CHANGE = ~bus.BUFER_CHANGE;
    endtask

    // One FSMC read: strobes low 10 CLK, high 10 CLK; the first word seen
    // with DATA_OE is scored against the scoreboard head.
    task automatic fsmc_read(input bit expect_oe, input string name);
        bit oe_any;
        logic [15:0] got;
        oe_any = 1'b0;
        got = '0;
        @(negedge clk);
        bus.FSMC_NE = 1'b0;
        bus.FSMC_NOE = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 9) begin
                bus.FSMC_NE = 1'b1;
                bus.FSMC_NOE = 1'b1;
            end
            if (bus.DATA_OE && !oe_any) begin
                oe_any = 1'b1;
                got = bus.DATA_OUT;
            end
        end
        check({name, " oe"}, 64'(oe_any), 64'(expect_oe));
        if (oe_any) begin
            if (sb_q.size() == 0) begin
                n_chk++;
                $display("FAIL %s word: got %0h required none (scoreboard empty)", name, got);
            end else begin
                check({name, " word"}, 64'(got), 64'(sb_q.pop_front()));
            end
        end
    endtask

    initial begin
        int bad;
        bit seen;
        mem[0] = '{16'hA000, 16'hA001, 16'hA002, 16'hA003};
        mem[1] = '{16'hB000, 16'hB001, 16'hB002, 16'hB003};
        tbl[0] = '{oe: 1'b1, cnt: 1, addr: 1, rdy: 1'b1};
        tbl[1] = '{oe: 1'b1, cnt: 2, addr: 2, rdy: 1'b1};
        tbl[2] = '{oe: 1'b1, cnt: 3, addr: 3, rdy: 1'b1};
        tbl[3] = '{oe: 1'b1, cnt: 4, addr: 3, rdy: 1'b0};
        tbl[4] = '{oe: 1'b0, cnt: 4, addr: 3, rdy: 1'b0};

        bus.BUFER_CHANGE = 1'b0;
        bus.BUFER_EN = 1'b0;
        bus.FSMC_NE = 1'b1;
        bus.FSMC_NOE = 1'b1;
        repeat (3) @(negedge clk);
        check("reset outs", outs(), 64'd0);
        rst_n = 1'b1;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (outs() != 64'd0) bad++;
        end
        check("idle 100 cycles nonzero", 64'(bad), 64'd0);

        // First bank: writer moves to bank 1, reader takes bank 0.
        toggle();
        push_bank(0);
        @(negedge clk);
        check("tgl mem_rd", 64'(bus.MEM_RD), 64'd1);
        check("tgl mem_sel", 64'(bus.MEM_SEL), 64'd0);
        check("tgl mem_addr", 64'(bus.MEM_ADDR), 64'd0);
        check("tgl ready early", 64'(bus.DATA_READY), 64'd0);
        @(negedge clk);
        check("tgl+1 mem_rd", 64'(bus.MEM_RD), 64'd0);
        check("tgl+1 ready", 64'(bus.DATA_READY), 64'd0);
        @(negedge clk);
        check("tgl+2 ready", 64'(bus.DATA_READY), 64'd1);
        check("tgl+2 data_out", 64'(bus.DATA_OUT), 64'hA000);

        for (int i = 0; i < 5; i++) begin
            fsmc_read(tbl[i].oe, $sformatf("drain%0d", i));
            check($sformatf("drain%0d word_cnt", i), 64'(bus.WORD_CNT), 64'(tbl[i].cnt));
            check($sformatf("drain%0d mem_addr", i), 64'(bus.MEM_ADDR), 64'(tbl[i].addr));
            check($sformatf("drain%0d ready", i), 64'(bus.DATA_READY), 64'(tbl[i].rdy));
        end
        check("drain overrun", 64'(bus.OVERRUN), 64'd0);

        // Overrun: new bank arrives after 2 of 4 reads.
        toggle();
        push_bank(1);
        repeat (3) @(negedge clk);
        check("bank1 sel", 64'(bus.MEM_SEL), 64'd1);
        check("bank1 ready", 64'(bus.DATA_READY), 64'd1);
        fsmc_read(1'b1, "b1r0");
        fsmc_read(1'b1, "b1r1");
        check("b1 word_cnt", 64'(bus.WORD_CNT), 64'd2);
        toggle();
        sb_q.delete();
        push_bank(0);
        @(negedge clk);
        check("ovr overrun", 64'(bus.OVERRUN), 64'd1);
        check("ovr sel", 64'(bus.MEM_SEL), 64'd0);
        check("ovr word_cnt", 64'(bus.WORD_CNT), 64'd0);
        check("ovr mem_addr", 64'(bus.MEM_ADDR), 64'd0);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) fsmc_read(1'b1, $sformatf("ovr_rd%0d", i));
        check("ovr sticky", 64'(bus.OVERRUN), 64'd1);
        check("ovr drained ready", 64'(bus.DATA_READY), 64'd0);

        // Strobe held low across a toggle.
        @(negedge clk);
        bus.FSMC_NE = 1'b0;
        bus.FSMC_NOE = 1'b0;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.DATA_OE && !bus.DATA_READY) bad++;
        end
        toggle();
        sb_q.delete();
        push_bank(1);
        repeat (10) begin
            @(negedge clk);
            if (bus.DATA_OE && !bus.DATA_READY) bad++;
        end
        bus.FSMC_NE = 1'b1;
        bus.FSMC_NOE = 1'b1;
        repeat (10) @(negedge clk);
        check("held oe outside ready", 64'(bad), 64'd0);
        check("held word_cnt", 64'(bus.WORD_CNT), 64'd0);
        fsmc_read(1'b1, "held_r0");
        fsmc_read(1'b1, "held_r1");
        check("held2 word_cnt", 64'(bus.WORD_CNT), 64'd2);

        // Reset in the middle of a read.
        @(negedge clk);
        bus.FSMC_NE = 1'b0;
        bus.FSMC_NOE = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (bus.DATA_OE) seen = 1'b1;
        end
        check("midread oe", 64'(seen), 64'd1);
        rst_n = 1'b0;
        #1;
        check("midread reset outs", outs(), 64'd0);
        bus.FSMC_NE = 1'b1;
        bus.FSMC_NOE = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post reset outs", outs(), 64'd0);
        toggle();
        sb_q.delete();
        push_bank(0);
        @(negedge clk);
        check("restart mem_rd", 64'(bus.MEM_RD), 64'd1);
        check("restart mem_addr", 64'(bus.MEM_ADDR), 64'd0);
        check("restart sel", 64'(bus.MEM_SEL), 64'd0);
        repeat (2) @(negedge clk);
        fsmc_read(1'b1, "restart_r0");
        check("restart word_cnt", 64'(bus.WORD_CNT), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
